// File: rtl/alarm_sequencer_pkg.sv
// alarm_sequencer_pkg: shared state encoding and widths for the alarm sequencer.
// Contents: state_t (DISARMED..SILENCED), STATE_W, DEB_W, is_alert().
package alarm_sequencer_pkg;

    localparam int STATE_W = 3;
    localparam int DEB_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED = 3'd0,
        ST_ARMED    = 3'd1,
        ST_PENDING  = 3'd2,
        ST_ALARM    = 3'd3,
        ST_SILENCED = 3'd4
    } state_t;

    function automatic logic is_alert(input state_t s);
        return (s == ST_ALARM) || (s == ST_SILENCED);
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if: control inputs and status outputs of the alarm sequencer.
// master drives arm/ack/alarm_in/sensors; slave drives siren/alarm_active/state_o/cause/event_cnt.
interface alarm_sequencer_if
    import alarm_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic               arm;
    logic               ack;
    logic               alarm_in;
    logic [2:0]         sensors;
    logic               siren;
    logic               alarm_active;
    logic [STATE_W-1:0] state_o;
    logic [2:0]         cause;
    logic [CNT_W-1:0]   event_cnt;

    modport master (
        output arm, ack, alarm_in, sensors,
        input  siren, alarm_active, state_o, cause, event_cnt
    );

    modport slave (
        input  arm, ack, alarm_in, sensors,
        output siren, alarm_active, state_o, cause, event_cnt
    );
endinterface

// File: rtl/alarm_debounce.sv
// alarm_debounce: consecutive-sample counter; hit flags the CYC-th high sample.
// Ports: clk, rst_n, clr (sync clear), sample (input level), hit (combinational).
module alarm_debounce
    import alarm_sequencer_pkg::*;
#(
    parameter int CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic sample,
    output logic hit
);

    logic [DEB_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || !sample) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + DEB_W'(1);
        end
    end

    // The sample arriving now is the CYC-th in a row.
    assign hit = sample && !clr && (32'(cnt_q) == CYC - 1);

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: debounces alarm_in, latches cause, pulses siren, counts events.
// Ports: clk, rst_n (async low), bus (alarm_sequencer_if.slave).
// Option: ALARM_AUTO_REARM_EN lets SILENCED return to ARMED after a quiet period.
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = 4,
    parameter int SIREN_ON      = 8,
    parameter int SIREN_OFF     = 8,
    parameter int ALARM_TIMEOUT = 64,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alarm_sequencer_if.slave     bus
);

    localparam int PER = SIREN_ON + SIREN_OFF;
    localparam int PW  = (PER > 1) ? $clog2(PER) : 1;
    localparam int TW  = (ALARM_TIMEOUT > 1) ? $clog2(ALARM_TIMEOUT) : 1;

    state_t           state_q, state_n;
    logic [PW-1:0]    phase_q, phase_n;
    logic [TW-1:0]    timer_q, timer_n;
    logic             siren_q, siren_n;
    logic             active_q, active_n;
    logic [2:0]       cause_q;
    logic [CNT_W-1:0] cnt_q;
    logic             enter_alarm;
    logic             trip_clr;
    logic             trip_hit;
    logic             rearm_hit;
    logic             tmo_hit;

    assign trip_clr = !bus.arm ||
                      !(state_q == ST_ARMED || state_q == ST_PENDING);

    alarm_debounce #(.CYC(DEBOUNCE_CYC)) u_trip (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (trip_clr),
        .sample (bus.alarm_in),
        .hit    (trip_hit)
    );

`ifdef ALARM_AUTO_REARM_EN
    logic rearm_clr;

    assign rearm_clr = !bus.arm || (state_q != ST_SILENCED);

    alarm_debounce #(.CYC(DEBOUNCE_CYC)) u_rearm (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rearm_clr),
        .sample (!bus.alarm_in),
        .hit    (rearm_hit)
    );
`else
    assign rearm_hit = 1'b0;
`endif

    // timer_q counts completed ALARM cycles; zero timeout disables it.
    assign tmo_hit = (ALARM_TIMEOUT != 0) &&
                     (32'(timer_q) == ALARM_TIMEOUT - 1);

    always_comb begin
        state_n     = state_q;
        phase_n     = '0;
        timer_n     = '0;
        siren_n     = 1'b0;
        active_n    = 1'b0;
        enter_alarm = 1'b0;

        if (!bus.arm) begin
            state_n = ST_DISARMED;
        end else begin
            unique case (state_q)
                ST_DISARMED: state_n = ST_ARMED;
                ST_ARMED: begin
                    if (bus.alarm_in) state_n = ST_PENDING;
                end
                ST_PENDING: begin
                    if (!bus.alarm_in) state_n = ST_ARMED;
                    else if (trip_hit) state_n = ST_ALARM;
                end
                ST_ALARM: begin
                    if (bus.ack || tmo_hit) state_n = ST_SILENCED;
                end
                ST_SILENCED: begin
                    if (rearm_hit) state_n = ST_ARMED;
                end
                default: state_n = ST_DISARMED;
            endcase
        end

        enter_alarm = (state_n == ST_ALARM) && (state_q != ST_ALARM);

        if (state_q == ST_ALARM && !enter_alarm) begin
            timer_n = timer_q + TW'(1);
            if (32'(phase_q) != PER - 1) phase_n = phase_q + PW'(1);
        end

        // Siren and active are registered from the next-cycle view.
        siren_n  = (state_n == ST_ALARM) && (32'(phase_n) < SIREN_ON);
        active_n = is_alert(state_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_DISARMED;
            phase_q  <= '0;
            timer_q  <= '0;
            siren_q  <= 1'b0;
            active_q <= 1'b0;
            cause_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_n;
            phase_q  <= phase_n;
            timer_q  <= timer_n;
            siren_q  <= siren_n;
            active_q <= active_n;
            if (enter_alarm) begin
                cause_q <= bus.sensors;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.state_o      = state_q;
    assign bus.siren        = siren_q;
    assign bus.alarm_active = active_q;
    assign bus.cause        = cause_q;
    assign bus.event_cnt    = cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: scoreboard bench for alarm_sequencer.
// Snapshots are {state, siren, active, cause, event_cnt}, shown in hex on FAIL.
module tb_alarm_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alarm_sequencer_if #(.CNT_W(8)) bus ();

    alarm_sequencer #(
        .DEBOUNCE_CYC  (4),
        .SIREN_ON      (8),
        .SIREN_OFF     (8),
        .ALARM_TIMEOUT (64),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       sir;
        logic       act;
        logic [2:0] cs;
        logic [7:0] cnt;
    } snap_t;

    snap_t      sb[$];
    snap_t      e;
    snap_t      o;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [2:0] exp_cs = 3'd0;

    function automatic snap_t observe();
        snap_t s;
        s.st  = bus.state_o;
        s.sir = bus.siren;
        s.act = bus.alarm_active;
        s.cs  = bus.cause;
        s.cnt = bus.event_cnt;
        return s;
    endfunction

    function automatic snap_t mk(input logic [2:0] st, input logic sir,
                                 input logic act, input logic [2:0] cs,
                                 input logic [7:0] cnt);
        snap_t s;
        s.st  = st;
        s.sir = sir;
        s.act = act;
        s.cs  = cs;
        s.cnt = cnt;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_disarmed();
        bus.arm      = 1'b0;
        bus.ack      = 1'b0;
        bus.alarm_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic go_alarm(input logic [2:0] s);
        go_disarmed();
        bus.arm = 1'b1;
        tick();
        bus.sensors  = s;
        bus.alarm_in = 1'b1;
        repeat (4) tick();
        bus.alarm_in = 1'b0;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        exp_cs = s;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.arm      = 1'b0;
        bus.ack      = 1'b0;
        bus.alarm_in = 1'b0;
        bus.sensors  = 3'b111;
        repeat (3) tick();
        sb.push_back(mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd0));
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_held: got=%h want=%h", o, e);
        end
        rst_n = 1'b1;
        sb.push_back(mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd0));
        tick();
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_release: got=%h want=%h", o, e);
        end
    endtask

    task automatic test_trip();
        bus.arm     = 1'b1;
        bus.sensors = 3'b101;
        sb.push_back(mk(3'd1, 1'b0, 1'b0, 3'b000, 8'd0));
        tick();
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL trip_armed: got=%h want=%h", o, e);
        end
        bus.alarm_in = 1'b1;
        for (int i = 0; i < 3; i++)
            sb.push_back(mk(3'd2, 1'b0, 1'b0, 3'b000, 8'd0));
        sb.push_back(mk(3'd3, 1'b1, 1'b1, 3'b101, 8'd1));
        exp_cnt = 8'd1;
        exp_cs  = 3'b101;
        for (int i = 0; i < 4; i++) begin
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL trip_edge%0d: got=%h want=%h", i + 1, o, e);
            end
        end
        bus.alarm_in = 1'b0;
        bus.sensors  = 3'b010;
        for (int j = 0; j < 17; j++) begin
            sb.push_back(mk(3'd3, (j % 16) < 8, 1'b1, 3'b101, 8'd1));
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL siren_cyc%0d: got=%h want=%h", j, o, e);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        go_disarmed();
        bus.arm = 1'b1;
        sb.push_back(mk(3'd1, 1'b0, 1'b0, exp_cs, exp_cnt));
        tick();
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL abort_armed: got=%h want=%h", o, e);
        end
        bus.alarm_in = 1'b1;
        for (int i = 0; i < 3; i++)
            sb.push_back(mk(3'd2, 1'b0, 1'b0, exp_cs, exp_cnt));
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL abort_pend%0d: got=%h want=%h", i, o, e);
            end
        end
        bus.alarm_in = 1'b0;
        sb.push_back(mk(3'd1, 1'b0, 1'b0, exp_cs, exp_cnt));
        tick();
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL abort_back: got=%h want=%h", o, e);
        end
    endtask

    task automatic test_ack();
        go_alarm(3'b011);
        repeat (10) tick();
        bus.ack = 1'b1;
        sb.push_back(mk(3'd4, 1'b0, 1'b1, 3'b011, exp_cnt));
        tick();
        bus.ack = 1'b0;
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL ack_silence: got=%h want=%h", o, e);
        end
        bus.alarm_in = 1'b1;
        bus.sensors  = 3'b100;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(mk(3'd4, 1'b0, 1'b1, 3'b011, exp_cnt));
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL silenced_hold%0d: got=%h want=%h", i, o, e);
            end
        end
        bus.alarm_in = 1'b0;
    endtask

    task automatic test_timeout();
        go_alarm(3'b110);
        repeat (63) tick();
        sb.push_back(mk(3'd3, 1'b0, 1'b1, 3'b110, exp_cnt));
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL tmo_last: got=%h want=%h", o, e);
        end
        sb.push_back(mk(3'd4, 1'b0, 1'b1, 3'b110, exp_cnt));
        tick();
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL tmo_fire: got=%h want=%h", o, e);
        end
    endtask

    task automatic test_ack_timeout();
        go_alarm(3'b100);
        repeat (63) tick();
        bus.ack = 1'b1;
        sb.push_back(mk(3'd4, 1'b0, 1'b1, 3'b100, exp_cnt));
        tick();
        bus.ack = 1'b0;
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL ack_tmo: got=%h want=%h", o, e);
        end
        go_disarmed();
        sb.push_back(mk(3'd0, 1'b0, 1'b0, 3'b100, exp_cnt));
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL ack_tmo_once: got=%h want=%h", o, e);
        end
    endtask

    task automatic test_disarm();
        go_disarmed();
        bus.arm = 1'b1;
        tick();
        bus.alarm_in = 1'b1;
        tick();
        tick();
        bus.arm = 1'b0;
        sb.push_back(mk(3'd0, 1'b0, 1'b0, exp_cs, exp_cnt));
        tick();
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL disarm_pend: got=%h want=%h", o, e);
        end
        go_alarm(3'b001);
        tick();
        tick();
        sb.push_back(mk(3'd3, 1'b1, 1'b1, 3'b001, exp_cnt));
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL disarm_pre: got=%h want=%h", o, e);
        end
        bus.arm = 1'b0;
        bus.ack = 1'b1;
        sb.push_back(mk(3'd0, 1'b0, 1'b0, 3'b001, exp_cnt));
        tick();
        bus.ack = 1'b0;
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL disarm_alarm: got=%h want=%h", o, e);
        end
        bus.alarm_in = 1'b1;
        sb.push_back(mk(3'd0, 1'b0, 1'b0, 3'b001, exp_cnt));
        tick();
        bus.alarm_in = 1'b0;
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL disarm_stay: got=%h want=%h", o, e);
        end
    endtask

    task automatic test_rearm();
        go_alarm(3'b111);
        bus.ack = 1'b1;
        sb.push_back(mk(3'd4, 1'b0, 1'b1, 3'b111, exp_cnt));
        tick();
        bus.ack = 1'b0;
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL rearm_sil: got=%h want=%h", o, e);
        end
        for (int i = 0; i < 3; i++)
            sb.push_back(mk(3'd4, 1'b0, 1'b1, 3'b111, exp_cnt));
`ifdef ALARM_AUTO_REARM_EN
        sb.push_back(mk(3'd1, 1'b0, 1'b0, 3'b111, exp_cnt));
`else
        sb.push_back(mk(3'd4, 1'b0, 1'b1, 3'b111, exp_cnt));
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rearm_q%0d: got=%h want=%h", i + 1, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        go_alarm(3'b101);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 8'd0;
        exp_cs  = 3'd0;
        sb.push_back(mk(3'd0, 1'b0, 1'b0, 3'b000, 8'd0));
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_mid: got=%h want=%h", o, e);
        end
        #1;
        rst_n = 1'b1;
        sb.push_back(mk(3'd1, 1'b0, 1'b0, 3'b000, 8'd0));
        tick();
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_mid_rel: got=%h want=%h", o, e);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 255; i++) go_alarm(3'b010);
        sb.push_back(mk(3'd3, 1'b1, 1'b1, 3'b010, 8'hFF));
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL sat_255: got=%h want=%h", o, e);
        end
        go_alarm(3'b110);
        sb.push_back(mk(3'd3, 1'b1, 1'b1, 3'b110, 8'hFF));
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL sat_hold: got=%h want=%h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_trip();
        test_abort();
        test_ack();
        test_timeout();
        test_ack_timeout();
        test_disarm();
        test_rearm();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
